// File: rtl/uplink_pkg.sv
// Shared types and constants for the multi-channel serial uplink deframer.
package uplink_pkg;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hB9AF2E5C;
    localparam int unsigned LEN_W             = 32;

    typedef enum logic [2:0] {
        HUNT,
        HEADER,
        LENGTH,
        PAYLOAD,
        CRC,
        DONE
    } state_e;

endpackage

// File: rtl/uplink_deframer_ch.sv
// One uplink channel: sync hunt, byte assembly, length latch and per-packet FSM.
module uplink_deframer_ch
    import uplink_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int unsigned HDR_BYTES   = 8,
    parameter int unsigned CRC_BYTES   = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_PAYLOAD = 112
) (
    input  logic              ul_clk,
    input  logic              rst_i,
    input  logic              ping_i,
    input  logic              ser_bit,
    input  logic              release_i,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-2:0] byte_idx,
    output logic              wren,
    output logic              formed,
    output logic              len_err
);

    localparam int unsigned     IDX_W     = ADDR_W - 1;
    localparam int unsigned     LEN_BYTES = LEN_W / 8;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);

    state_e           state;
    logic [31:0]      sr;
    logic [2:0]       bit_cnt;
    logic [IDX_W-1:0] fld_cnt;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;

    logic [7:0]       new_byte;
    logic             byte_done;
    logic [LEN_W-1:0] len_next;
    logic             fld_last;

    assign new_byte  = {sr[6:0], ser_bit};
    assign byte_done = (bit_cnt == 3'd7);
    assign len_next  = {len[LEN_W-9:0], new_byte};

    // Last byte of the current field
    always_comb begin
        fld_last = 1'b0;
        case (state)
            HEADER:  fld_last = (fld_cnt == IDX_W'(HDR_BYTES - 1));
            LENGTH:  fld_last = (fld_cnt == IDX_W'(LEN_BYTES - 1));
            PAYLOAD: fld_last = (LEN_W'(fld_cnt) == (len - LEN_W'(1)));
            CRC:     fld_last = (fld_cnt == IDX_W'(CRC_BYTES - 1));
            default: fld_last = 1'b0;
        endcase
    end

    always_ff @(posedge ul_clk) begin
        if (rst_i) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            fld_cnt   <= '0;
            idx       <= '0;
            len       <= '0;
            byte_data <= '0;
            byte_idx  <= '0;
            wren      <= 1'b0;
            formed    <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            sr   <= {sr[30:0], ser_bit};
            wren <= 1'b0;
            case (state)
                HUNT: begin
                    idx <= '0;
                    // The bit arriving with the match is already header bit 7
                    if (sr == SYNC_WORD && !ping_i) begin
                        state   <= HEADER;
                        bit_cnt <= 3'd1;
                        fld_cnt <= '0;
                    end
                end
                HEADER, LENGTH, PAYLOAD, CRC: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        wren      <= 1'b1;
                        byte_data <= new_byte;
                        byte_idx  <= idx;
                        idx       <= idx + IDX_W'(1);
                        fld_cnt   <= fld_last ? '0 : fld_cnt + IDX_W'(1);
                        if (state == LENGTH) begin
                            len <= len_next;
                        end
                        if (fld_last) begin
                            case (state)
                                HEADER: state <= LENGTH;
                                LENGTH: begin
                                    if (len_next > MAX_LEN) begin
                                        state   <= DONE;
                                        formed  <= 1'b1;
                                        len_err <= 1'b1;
                                    end else if (len_next == '0) begin
                                        state <= CRC;
                                    end else begin
                                        state <= PAYLOAD;
                                    end
                                end
                                PAYLOAD: state <= CRC;
                                default: begin
                                    state  <= DONE;
                                    formed <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    if (release_i) begin
                        state   <= HUNT;
                        formed  <= 1'b0;
                        len_err <= 1'b0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: rtl/uplink_deframer.sv
// Multi-channel uplink deframer: per-channel deframers plus the all-channels completion barrier.
module uplink_deframer
    import uplink_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int unsigned HDR_BYTES   = 8,
    parameter int unsigned CRC_BYTES   = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_PAYLOAD = 112
) (
    input  logic                     ul_clk,
    input  logic                     rst_i,
    input  logic                     ping_i,
    input  logic [NUM_CH-1:0]        ul_data,
    input  logic                     ram_page,
    output logic [NUM_CH*8-1:0]      out_data,
    output logic [NUM_CH*ADDR_W-1:0] out_addr,
    output logic [NUM_CH-1:0]        wren,
    output logic [NUM_CH-1:0]        packet_formed,
    output logic [NUM_CH-1:0]        len_err,
    output logic                     all_formed
);

    logic barrier;

    // Every channel holds a packet; released channels drop formed on the next edge
    assign barrier    = &packet_formed;
    assign all_formed = barrier;

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        logic [ADDR_W-2:0] idx;

        uplink_deframer_ch #(
            .SYNC_WORD   (SYNC_WORD),
            .HDR_BYTES   (HDR_BYTES),
            .CRC_BYTES   (CRC_BYTES),
            .ADDR_W      (ADDR_W),
            .MAX_PAYLOAD (MAX_PAYLOAD)
        ) u_ch (
            .ul_clk    (ul_clk),
            .rst_i     (rst_i),
            .ping_i    (ping_i),
            .ser_bit   (ul_data[c]),
            .release_i (barrier),
            .byte_data (out_data[8*c +: 8]),
            .byte_idx  (idx),
            .wren      (wren[c]),
            .formed    (packet_formed[c]),
            .len_err   (len_err[c])
        );

        assign out_addr[ADDR_W*c +: ADDR_W] = {ram_page, idx};
    end

endmodule

// File: tb/tb_uplink_deframer.sv
// Directed bench for uplink_deframer: 2-channel table vectors, corner sequences, 4-channel barrier.
module tb_uplink_deframer;
    import uplink_pkg::*;

    localparam int unsigned NSTR = 6;
    localparam int unsigned SMAX = 1200;

    logic ul_clk = 1'b0;
    always #5 ul_clk = ~ul_clk;

    logic        rst_i, ping_i, ram_page2, ram_page4;
    logic [1:0]  ul2;
    logic [3:0]  ul4;
    logic [15:0] out_data2, out_addr2;
    logic [31:0] out_data4, out_addr4;
    logic [1:0]  wren2, pf2, le2;
    logic [3:0]  wren4, pf4, le4;
    logic        af2, af4;

    uplink_deframer #(.NUM_CH(2)) dut (
        .ul_clk(ul_clk), .rst_i(rst_i), .ping_i(ping_i), .ul_data(ul2), .ram_page(ram_page2),
        .out_data(out_data2), .out_addr(out_addr2), .wren(wren2), .packet_formed(pf2),
        .len_err(le2), .all_formed(af2)
    );

    uplink_deframer #(.NUM_CH(4)) dut4 (
        .ul_clk(ul_clk), .rst_i(rst_i), .ping_i(ping_i), .ul_data(ul4), .ram_page(ram_page4),
        .out_data(out_data4), .out_addr(out_addr4), .wren(wren4), .packet_formed(pf4),
        .len_err(le4), .all_formed(af4)
    );

    typedef struct {
        int unsigned len;
        logic        sync_pl;
        int          wr;
        logic        le;
        logic [7:0]  b11;
        logic [7:0]  b12;
        logic [7:0]  last;
    } vec_t;

    logic       strm [NSTR][SMAX];
    logic [7:0] mem [NSTR][128];
    int         wcnt [NSTR], seq_err [NSTR], msb_err [NSTR], first_cyc [NSTR];
    logic       pf_seen [NSTR], le_seen [NSTR];
    int         af_cnt [2], af_cyc [2];
    int         cyc, ping_until, checks, errors;
    vec_t       vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put_bits(input int c, input int pos, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) strm[c][pos+i] = v[n-1-i];
    endtask

    function automatic int pkt_bytes(input int unsigned l);
        return 12 + ((l <= 112) ? int'(l) + 4 : 0);
    endfunction

    task automatic place_packet(input int c, input int start, input int unsigned l, input logic sync_pl);
        int p;
        logic [31:0] b;
        p = start;
        put_bits(c, p, SYNC_WORD_DEFAULT, 32); p += 32;
        for (int i = 0; i < 8; i++) begin put_bits(c, p, 32'(i + 1), 8); p += 8; end
        put_bits(c, p, 32'(l), 32); p += 32;
        if (l <= 112) begin
            for (int i = 0; i < int'(l); i++) begin
                b = sync_pl ? (SYNC_WORD_DEFAULT >> (24 - 8*(i % 4))) : 32'(170 + 17*i);
                put_bits(c, p, {24'd0, b[7:0]}, 8); p += 8;
            end
            for (int i = 0; i < 4; i++) begin put_bits(c, p, 32'(17*(i + 1)), 8); p += 8; end
        end
    endtask

    task automatic clear_streams();
        for (int c = 0; c < NSTR; c++)
            for (int i = 0; i < SMAX; i++) strm[c][i] = 1'b0;
    endtask

    task automatic clear_logs();
        for (int c = 0; c < NSTR; c++) begin
            wcnt[c] = 0; seq_err[c] = 0; msb_err[c] = 0; first_cyc[c] = -1;
            pf_seen[c] = 1'b0; le_seen[c] = 1'b0;
            for (int a = 0; a < 128; a++) mem[c][a] = 8'h00;
        end
        for (int k = 0; k < 2; k++) begin af_cnt[k] = 0; af_cyc[k] = -1; end
    endtask

    task automatic sample();
        for (int c = 0; c < NSTR; c++) begin
            logic       w, p, l, pg;
            logic [7:0] a, d;
            if (c < 2) begin
                w = wren2[c]; a = out_addr2[8*c +: 8]; d = out_data2[8*c +: 8];
                p = pf2[c]; l = le2[c]; pg = ram_page2;
            end else begin
                w = wren4[c-2]; a = out_addr4[8*(c-2) +: 8]; d = out_data4[8*(c-2) +: 8];
                p = pf4[c-2]; l = le4[c-2]; pg = ram_page4;
            end
            if (w) begin
                if (a[6:0] != 7'(wcnt[c])) seq_err[c]++;
                if (a[7] != pg) msb_err[c]++;
                mem[c][a[6:0]] = d;
                if (wcnt[c] == 0) first_cyc[c] = cyc;
                wcnt[c]++;
            end
            if (p) pf_seen[c] = 1'b1;
            if (l) le_seen[c] = 1'b1;
        end
        if (af2) begin af_cnt[0]++; af_cyc[0] = cyc; end
        if (af4) begin af_cnt[1]++; af_cyc[1] = cyc; end
    endtask

    // Each iteration: sample outputs at negedge, then drive stream bit cyc for the next posedge
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge ul_clk);
            sample();
            ping_i = (cyc < ping_until);
            for (int c = 0; c < NSTR; c++) begin
                if (c < 2) ul2[c]   = (cyc < int'(SMAX)) ? strm[c][cyc] : 1'b0;
                else       ul4[c-2] = (cyc < int'(SMAX)) ? strm[c][cyc] : 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) begin
            @(negedge ul_clk);
            ul2 = '0; ul4 = '0; ping_i = 1'b0;
        end
        rst_i = 1'b0;
        clear_logs();
        cyc = 0;
        ping_until = 0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; ping_until = 0;
        rst_i = 1'b1; ping_i = 1'b0; ul2 = '0; ul4 = '0;
        ram_page2 = 1'b0; ram_page4 = 1'b1;
        clear_streams();
        clear_logs();

        vecs[0] = '{4,   1'b0, 20,  1'b0, 8'h04, 8'hAA, 8'h44};
        vecs[1] = '{0,   1'b0, 16,  1'b0, 8'h00, 8'h11, 8'h44};
        vecs[2] = '{113, 1'b0, 12,  1'b1, 8'h71, 8'h00, 8'h71};
        vecs[3] = '{112, 1'b0, 128, 1'b0, 8'h70, 8'hAA, 8'h44};
        vecs[4] = '{1,   1'b0, 17,  1'b0, 8'h01, 8'hAA, 8'h44};
        vecs[5] = '{4,   1'b1, 20,  1'b0, 8'h04, 8'hB9, 8'h44};

        // Reset state
        do_reset();
        check("rst wren", 32'(wren2), 32'd0);
        check("rst data", 32'(out_data2), 32'd0);
        check("rst addr", 32'(out_addr2), 32'd0);
        check("rst formed", {28'd0, pf2, le2}, 32'd0);
        check("rst all_formed", {30'd0, af2, af4}, 32'd0);
        check("rst wren4", 32'(wren4), 32'd0);

        // Table: one packet on both channels with varied length fields
        for (int v = 0; v < 6; v++) begin
            int n;
            clear_streams();
            place_packet(0, 0, vecs[v].len, vecs[v].sync_pl);
            place_packet(1, 0, vecs[v].len, vecs[v].sync_pl);
            do_reset();
            n = pkt_bytes(vecs[v].len);
            run_cycles(32 + 8*n + 16);
            for (int c = 0; c < 2; c++) begin
                check($sformatf("v%0d ch%0d writes", v, c), 32'(wcnt[c]), 32'(vecs[v].wr));
                check($sformatf("v%0d ch%0d addr seq", v, c), 32'(seq_err[c]), 32'd0);
                check($sformatf("v%0d ch%0d len_err", v, c), 32'(le_seen[c]), 32'(vecs[v].le));
                check($sformatf("v%0d ch%0d formed", v, c), 32'(pf_seen[c]), 32'd1);
                check($sformatf("v%0d ch%0d byte11", v, c), 32'(mem[c][11]), 32'(vecs[v].b11));
                check($sformatf("v%0d ch%0d last byte", v, c), 32'(mem[c][7'(wcnt[c] - 1)]), 32'(vecs[v].last));
                if (vecs[v].wr > 12)
                    check($sformatf("v%0d ch%0d byte12", v, c), 32'(mem[c][12]), 32'(vecs[v].b12));
            end
            check($sformatf("v%0d all_formed count", v), 32'(af_cnt[0]), 32'd1);
            check($sformatf("v%0d all_formed cycle", v), 32'(af_cyc[0]), 32'(32 + 8*n));
            check($sformatf("v%0d formed cleared", v), 32'(pf2), 32'd0);
        end

        // ping_i masks the first sync; the second one 40 bits later is captured
        clear_streams();
        place_packet(0, 0, 4, 1'b0);
        place_packet(1, 0, 4, 1'b0);
        for (int c = 0; c < 2; c++) begin
            for (int i = 32; i < 72; i++) strm[c][i] = 1'b0;
            place_packet(c, 72, 4, 1'b0);
        end
        do_reset();
        ping_until = 40;
        run_cycles(300);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("ping ch%0d first write cyc", c), 32'(first_cyc[c]), 32'd112);
            check($sformatf("ping ch%0d writes", c), 32'(wcnt[c]), 32'd20);
            check($sformatf("ping ch%0d byte0", c), 32'(mem[c][0]), 32'h01);
        end
        check("ping all_formed count", 32'(af_cnt[0]), 32'd1);

        // Channel 0 finishes 200 clocks ahead of channel 1
        clear_streams();
        place_packet(0, 0, 4, 1'b0);
        place_packet(1, 200, 4, 1'b0);
        do_reset();
        run_cycles(300);
        check("skew formed hold", 32'(pf2), 32'd1);
        check("skew early all_formed", 32'(af_cnt[0]), 32'd0);
        run_cycles(120);
        check("skew all_formed count", 32'(af_cnt[0]), 32'd1);
        check("skew all_formed cycle", 32'(af_cyc[0]), 32'd392);
        check("skew ch0 writes", 32'(wcnt[0]), 32'd20);
        check("skew ch1 writes", 32'(wcnt[1]), 32'd20);

        // Reset mid-payload, then a fresh packet
        clear_streams();
        for (int c = 0; c < 2; c++) begin
            place_packet(c, 0, 4, 1'b0);
            place_packet(c, 160, 4, 1'b0);
            for (int i = 140; i < 160; i++) strm[c][i] = 1'b0;
        end
        do_reset();
        run_cycles(140);
        check("midrst writes before", 32'(wcnt[0]), 32'd13);
        rst_i = 1'b1;
        run_cycles(1);
        @(posedge ul_clk);
        #1;
        rst_i = 1'b0;
        check("midrst wren", 32'(wren2), 32'd0);
        check("midrst data", 32'(out_data2), 32'd0);
        check("midrst addr", 32'(out_addr2), 32'd0);
        check("midrst formed", {28'd0, pf2, le2}, 32'd0);
        clear_logs();
        run_cycles(260);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("midrst ch%0d first write cyc", c), 32'(first_cyc[c]), 32'd200);
            check($sformatf("midrst ch%0d writes", c), 32'(wcnt[c]), 32'd20);
            check($sformatf("midrst ch%0d addr seq", c), 32'(seq_err[c]), 32'd0);
        end
        check("midrst all_formed cycle", 32'(af_cyc[0]), 32'd352);

        // Four channels, staggered, page bit set
        clear_streams();
        for (int c = 2; c < 6; c++) place_packet(c, 50*(c-2), 4, 1'b0);
        do_reset();
        run_cycles(330);
        check("ch4 early all_formed", 32'(af_cnt[1]), 32'd0);
        run_cycles(40);
        for (int c = 2; c < 6; c++) begin
            check($sformatf("ch4 %0d writes", c-2), 32'(wcnt[c]), 32'd20);
            check($sformatf("ch4 %0d page bit", c-2), 32'(msb_err[c]), 32'd0);
            check($sformatf("ch4 %0d addr seq", c-2), 32'(seq_err[c]), 32'd0);
        end
        check("ch4 all_formed count", 32'(af_cnt[1]), 32'd1);
        check("ch4 all_formed cycle", 32'(af_cyc[1]), 32'd342);
        check("ch4 idle 2ch writes", 32'(wcnt[0] + wcnt[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
